// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrub engine for an ECC-protected RAM.
// It walks every address, reads it through the RAM's correcting port, and
// writes corrected data back unless the host touched the same word meanwhile.
// Corrected and uncorrectable events are counted with saturating counters.
module ecc_scrubber #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_BITS      = 16,
  parameter int RAM_RD_LATENCY = 4,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_BITS-1:0]  ram_data,
  output logic                  ram_wren,
  input  logic [DATA_BITS-1:0]  ram_q,
  input  logic [2:0]            ram_err,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic                  host_wren,
  output logic [15:0]           corr_count,
  output logic [15:0]           uncorr_count,
  output logic [ADDR_WIDTH-1:0] last_uncorr_addr,
  output logic                  pass_done,
  output logic                  busy
);

  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int LW = (RAM_RD_LATENCY > 1) ? $clog2(RAM_RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT, READ, LAT, CHECK, WRITE, NEXT
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ptr_reg;
  logic [IW-1:0]           wait_cnt_reg;
  logic [LW-1:0]           lat_cnt_reg;
  logic [DATA_BITS-1:0]    q_reg;
  logic [2:0]              err_reg;
  logic                    coll_reg;
  logic [15:0]             corr_reg;
  logic [15:0]             uncorr_reg;
  logic [ADDR_WIDTH-1:0]   last_uncorr_reg;
  logic [DATA_BITS-1:0]    data_reg;
  logic                    host_hit;
  logic                    coll_now;

  // Host write aimed at the word currently being scrubbed.
  assign host_hit = host_wren && (host_address == ptr_reg);
  // In CHECK the live host write counts as a collision too.
  assign coll_now = coll_reg || host_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decision; enable is only honoured at IDLE/WAIT/NEXT so a word in flight always completes.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (enable) state_next = WAIT;
      WAIT: begin
        if (!enable)                 state_next = IDLE;
        else if (wait_cnt_reg == '0) state_next = READ;
      end
      READ:  state_next = LAT;
      LAT:   if (lat_cnt_reg == '0) state_next = CHECK;
      CHECK: begin
        state_next = NEXT;
        if ((|err_reg) && !err_reg[2] && err_reg[1] && !coll_now)
          state_next = WRITE;
      end
      WRITE: state_next = NEXT;
      NEXT:  state_next = enable ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Idle-interval counter: reloaded whenever a new wait period starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_reg <= '0;
    else if ((state_reg == IDLE && enable) || state_reg == NEXT)
      wait_cnt_reg <= IW'(SCRUB_INTERVAL - 1);
    else if (state_reg == WAIT && wait_cnt_reg != '0)
      wait_cnt_reg <= wait_cnt_reg - IW'(1);
  end

  // Read-latency counter; the last LAT cycle is the one where q/err are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    lat_cnt_reg <= '0;
    else if (state_reg == READ)    lat_cnt_reg <= LW'(RAM_RD_LATENCY - 1);
    else if (state_reg == LAT && lat_cnt_reg != '0)
      lat_cnt_reg <= lat_cnt_reg - LW'(1);
  end

  // Capture corrected data and error flags when the read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      err_reg <= '0;
    end else if (state_reg == LAT && lat_cnt_reg == '0) begin
      q_reg   <= ram_q;
      err_reg <= ram_err;
    end
  end

  // Collision flag: armed fresh for each word, set by host writes during the read window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  coll_reg <= 1'b0;
    else if (state_next == READ && state_reg != READ) coll_reg <= 1'b0;
    else if ((state_reg == READ || state_reg == LAT) && host_hit)
      coll_reg <= 1'b1;
  end

  // Error bookkeeping; uncorrectable wins over corrected, counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_reg        <= '0;
      uncorr_reg      <= '0;
      last_uncorr_reg <= '0;
    end else if (state_reg == CHECK && (|err_reg)) begin
      if (err_reg[2]) begin
        if (uncorr_reg != 16'hFFFF) uncorr_reg <= uncorr_reg + 16'd1;
        last_uncorr_reg <= ptr_reg;
      end else if (err_reg[1]) begin
        if (corr_reg != 16'hFFFF) corr_reg <= corr_reg + 16'd1;
      end
    end
  end

  // Write-back data is latched on the way into WRITE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_reg <= '0;
    else if (state_reg == CHECK && state_next == WRITE) data_reg <= q_reg;
  end

  // Scrub pointer advances once per word and survives IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr_reg <= '0;
    else if (state_reg == NEXT) ptr_reg <= ptr_reg + ADDR_WIDTH'(1);
  end

  assign ram_address      = ptr_reg;
  assign ram_data         = data_reg;
  assign ram_wren         = (state_reg == WRITE);
  assign corr_count       = corr_reg;
  assign uncorr_count     = uncorr_reg;
  assign last_uncorr_addr = last_uncorr_reg;
  assign pass_done        = (state_reg == NEXT) && (&ptr_reg);
  assign busy             = (state_reg != IDLE) && (state_reg != WAIT);

endmodule
